// File: rtl/wb_rxfifo_pkg.sv
// Shared constants and helpers for the packing Wishbone RX FIFO.
package wb_rxfifo_pkg;

    localparam int WB_DATA_WIDTH  = 32;
    localparam int DROP_CNT_WIDTH = 16;

    // Number of stream samples that make up one bus word.
    function automatic int slots(input int rx_width);
        return WB_DATA_WIDTH / rx_width;
    endfunction

    // Width of the slot index register; never narrower than one bit.
    function automatic int slotIdxWidth(input int nSlots);
        return (nSlots > 1) ? $clog2(nSlots) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Dual-pointer word storage with one write port and a registered read port.
// The read word appears on rdData_o the cycle after rdEn_i.
module fifo_sync_mem #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  wrEn_i,
    input  logic [ADDR_WIDTH-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]      wrData_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_WIDTH-1:0] rdAddr_i,
    output logic [WIDTH-1:0]      rdData_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rdData_q;

    // Store a completed word at the write pointer.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // Capture the head word so it lines up with the bus acknowledge.
    always_ff @(posedge clk_i) begin
        if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/wb_rxfifo_pack.sv
// Packs a narrow valid/ready sample stream LSB-first into 32-bit words and
// buffers them for a pipelined Wishbone reader. A bus write flushes.
// Optional feature macro: WB_RXFIFO_PACK_STATS_EN adds o_drop_count.
module wb_rxfifo_pack
    import wb_rxfifo_pkg::*;
#(
    parameter int RX_WIDTH        = 8,
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int DROP_ON_FULL    = 0,
    parameter int LEVEL_THRESH    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    input  logic                       i_wb_we,
    output logic                       o_wb_stall,
    output logic                       o_wb_ack,
    output logic [WB_DATA_WIDTH-1:0]   o_wb_data,
    input  logic                       i_rx_valid,
    output logic                       o_rx_ready,
    input  logic [RX_WIDTH-1:0]        i_rx_data,
    output logic [FIFO_ADDR_WIDTH:0]   o_fifo_count,
    output logic                       o_fifo_empty,
    output logic                       o_fifo_full,
    output logic                       o_fifo_half_full,
    output logic                       o_fifo_level,
    output logic                       o_fifo_overflow,
    output logic                       o_fifo_underflow
`ifdef WB_RXFIFO_PACK_STATS_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0]  o_drop_count
`endif
);

    localparam int SLOTS  = slots(RX_WIDTH);
    localparam int SLOT_W = slotIdxWidth(SLOTS);
    localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
    localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic [SLOT_W-1:0]          slotIdx_q, slotIdx_d;
    logic [WB_DATA_WIDTH-1:0]   pack_q, pack_d;
    logic [FIFO_ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;
    logic                       empty_q, full_q, half_q, level_q;
    logic                       ack_q, ackPop_q;

    logic                       rxReady, rxFire, lastSlot;
    logic                       wbReq, wbRead, wbFlush;
    logic                       pushEn, popEn, dropWord;
    logic [31:0]                laneShift;
    logic [WB_DATA_WIDTH-1:0]   laneMask, laneData;
    logic [WB_DATA_WIDTH-1:0]   ramRdData;

    // Decode stream and bus handshakes into push/pop/drop events.
    always_comb begin
        lastSlot = (slotIdx_q == LAST_SLOT);
        rxReady  = 1'b1;
        if (DROP_ON_FULL == 0) begin
            rxReady = !(full_q && lastSlot);
        end
        rxFire   = i_rx_valid && rxReady;
        wbReq    = i_wb_cyc && i_wb_stb;
        wbFlush  = wbReq && i_wb_we;
        wbRead   = wbReq && !i_wb_we;
        pushEn   = rxFire && lastSlot && !wbFlush && (count_q != DEPTH_CNT);
        dropWord = (DROP_ON_FULL != 0) && rxFire && lastSlot && !wbFlush
                   && (count_q == DEPTH_CNT);
        popEn    = wbRead && (count_q != '0);
    end

    // Next-state for packer, pointers, occupancy and sticky flags.
    always_comb begin
        laneShift   = 32'(slotIdx_q) * 32'(RX_WIDTH);
        laneMask    = WB_DATA_WIDTH'({RX_WIDTH{1'b1}}) << laneShift;
        laneData    = WB_DATA_WIDTH'(i_rx_data) << laneShift;
        pack_d      = pack_q;
        slotIdx_d   = slotIdx_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wbFlush) begin
            pack_d      = '0;
            slotIdx_d   = '0;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (rxFire) begin
                pack_d    = (pack_q & ~laneMask) | laneData;
                slotIdx_d = lastSlot ? '0 : slotIdx_q + SLOT_W'(1);
            end
            if (pushEn) begin
                wrPtr_d = wrPtr_q + FIFO_ADDR_WIDTH'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + FIFO_ADDR_WIDTH'(1);
            end
            case ({pushEn, popEn})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (dropWord) begin
                overflow_d = 1'b1;
            end
            if (wbRead && (count_q == '0)) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Register all state; flags are derived from the next count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slotIdx_q   <= '0;
            pack_q      <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            half_q      <= 1'b0;
            level_q     <= 1'b0;
            ack_q       <= 1'b0;
            ackPop_q    <= 1'b0;
        end else begin
            slotIdx_q   <= slotIdx_d;
            pack_q      <= pack_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DEPTH_CNT);
            half_q      <= (32'(count_d) >= 32'(DEPTH / 2));
            level_q     <= (32'(count_d) >= 32'(LEVEL_THRESH));
            ack_q       <= wbReq;
            ackPop_q    <= popEn;
        end
    end

    fifo_sync_mem #(
        .WIDTH      (WB_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) uMem (
        .clk_i    (i_clk),
        .wrEn_i   (pushEn),
        .wrAddr_i (wrPtr_q),
        .wrData_i (pack_d),
        .rdEn_i   (popEn),
        .rdAddr_i (rdPtr_q),
        .rdData_o (ramRdData)
    );

`ifdef WB_RXFIFO_PACK_STATS_EN
    logic [DROP_CNT_WIDTH-1:0] dropCount_q, dropCount_d;
    logic                      dropEvent;

    // Saturating count of dropped words or stalled stream cycles.
    always_comb begin
        dropEvent   = 1'b0;
        dropCount_d = dropCount_q;
        if (DROP_ON_FULL != 0) begin
            dropEvent = dropWord;
        end else begin
            dropEvent = i_rx_valid && !rxReady;
        end
        if (wbFlush) begin
            dropCount_d = '0;
        end else if (dropEvent && (dropCount_q != '1)) begin
            dropCount_d = dropCount_q + DROP_CNT_WIDTH'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dropCount_q <= '0;
        end else begin
            dropCount_q <= dropCount_d;
        end
    end

    assign o_drop_count = dropCount_q;
`endif

    assign o_wb_stall       = 1'b0;
    assign o_wb_ack         = ack_q;
    assign o_wb_data        = ackPop_q ? ramRdData : '0;
    assign o_rx_ready       = rxReady;
    assign o_fifo_count     = count_q;
    assign o_fifo_empty     = empty_q;
    assign o_fifo_full      = full_q;
    assign o_fifo_half_full = half_q;
    assign o_fifo_level     = level_q;
    assign o_fifo_overflow  = overflow_q;
    assign o_fifo_underflow = underflow_q;

endmodule

// File: tb/tb_wb_rxfifo_pack.sv
// Bench for wb_rxfifo_pack: one backpressure instance checked against a
// queue-based reference model, one drop-mode instance checked directly.
// Optional feature macro: WB_RXFIFO_PACK_STATS_EN.
module tb_wb_rxfifo_pack;

    localparam int DEPTH    = 8;
    localparam int SLOTS    = 4;
    localparam int BP_LEVEL = 6;

    logic clk = 1'b0;
    logic rstN;
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    logic        bpCyc, bpStb, bpWe, bpValid;
    logic [7:0]  bpData;
    logic        bpStall, bpAck, bpReady, bpEmpty, bpFull, bpHalf, bpLevel, bpOver, bpUnder;
    logic [31:0] bpWbData;
    logic [3:0]  bpCount;

    logic        drCyc, drStb, drWe, drValid;
    logic [7:0]  drData;
    logic        drStall, drAck, drReady, drEmpty, drFull, drHalf, drLevel, drOver, drUnder;
    logic [31:0] drWbData;
    logic [3:0]  drCount;

`ifdef WB_RXFIFO_PACK_STATS_EN
    logic [15:0] bpDropCount, drDropCount;
`endif

    wb_rxfifo_pack #(
        .RX_WIDTH(8), .FIFO_ADDR_WIDTH(3), .DROP_ON_FULL(0), .LEVEL_THRESH(BP_LEVEL)
    ) dutBp (
        .i_clk(clk), .i_rst_n(rstN),
        .i_wb_cyc(bpCyc), .i_wb_stb(bpStb), .i_wb_we(bpWe),
        .o_wb_stall(bpStall), .o_wb_ack(bpAck), .o_wb_data(bpWbData),
        .i_rx_valid(bpValid), .o_rx_ready(bpReady), .i_rx_data(bpData),
        .o_fifo_count(bpCount), .o_fifo_empty(bpEmpty), .o_fifo_full(bpFull),
        .o_fifo_half_full(bpHalf), .o_fifo_level(bpLevel),
        .o_fifo_overflow(bpOver), .o_fifo_underflow(bpUnder)
`ifdef WB_RXFIFO_PACK_STATS_EN
        , .o_drop_count(bpDropCount)
`endif
    );

    wb_rxfifo_pack #(
        .RX_WIDTH(8), .FIFO_ADDR_WIDTH(3), .DROP_ON_FULL(1), .LEVEL_THRESH(4)
    ) dutDrop (
        .i_clk(clk), .i_rst_n(rstN),
        .i_wb_cyc(drCyc), .i_wb_stb(drStb), .i_wb_we(drWe),
        .o_wb_stall(drStall), .o_wb_ack(drAck), .o_wb_data(drWbData),
        .i_rx_valid(drValid), .o_rx_ready(drReady), .i_rx_data(drData),
        .o_fifo_count(drCount), .o_fifo_empty(drEmpty), .o_fifo_full(drFull),
        .o_fifo_half_full(drHalf), .o_fifo_level(drLevel),
        .o_fifo_overflow(drOver), .o_fifo_underflow(drUnder)
`ifdef WB_RXFIFO_PACK_STATS_EN
        , .o_drop_count(drDropCount)
`endif
    );

    // Reference model state for the backpressure instance.
    logic [31:0] modelQ[$];
    logic [7:0]  partial[$];
    bit          mUnder;
    int          mStats;
    bit          modelFire;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        modelQ.delete();
        partial.delete();
        mUnder = 1'b0;
        mStats = 0;
    endtask

    // One bus/stream cycle on the backpressure instance, checked against the model.
    task automatic applyStimulus(input bit v, input logic [7:0] d,
                                 input bit cyc, input bit stb, input bit we);
        bit          expReady, req, flush, doRead, expAck;
        int          sizeBefore, sz;
        logic [31:0] word, expData;
        bpValid = v; bpData = d; bpCyc = cyc; bpStb = stb; bpWe = we;
        sizeBefore = modelQ.size();
        expReady   = !(sizeBefore == DEPTH && partial.size() == SLOTS - 1);
        checkOutput("rx_ready", 32'(bpReady), 32'(expReady));
        checkOutput("wb_stall", 32'(bpStall), 32'd0);
        req       = cyc && stb;
        flush     = req && we;
        doRead    = req && !we;
        modelFire = v && expReady;
        expAck    = req;
        expData   = 32'd0;
        if (flush) begin
            resetModel();
        end else begin
            if (doRead) begin
                if (sizeBefore > 0) expData = modelQ.pop_front();
                else mUnder = 1'b1;
            end
            if (modelFire) begin
                partial.push_back(d);
                if (partial.size() == SLOTS) begin
                    word = 32'd0;
                    for (int i = 0; i < SLOTS; i++) word |= 32'(partial[i]) << (8 * i);
                    partial.delete();
                    if (sizeBefore < DEPTH) modelQ.push_back(word);
                end
            end
            if (v && !expReady && mStats < 65535) mStats++;
        end
        @(posedge clk);
        #1;
        sz = modelQ.size();
        checkOutput("ack", 32'(bpAck), 32'(expAck));
        if (expAck) checkOutput("ack_data", bpWbData, expData);
        checkOutput("count", 32'(bpCount), 32'(sz));
        checkOutput("empty", 32'(bpEmpty), 32'(sz == 0));
        checkOutput("full", 32'(bpFull), 32'(sz == DEPTH));
        checkOutput("half_full", 32'(bpHalf), 32'(sz >= DEPTH / 2));
        checkOutput("level", 32'(bpLevel), 32'(sz >= BP_LEVEL));
        checkOutput("overflow", 32'(bpOver), 32'd0);
        checkOutput("underflow", 32'(bpUnder), 32'(mUnder));
`ifdef WB_RXFIFO_PACK_STATS_EN
        checkOutput("bp_drop_count", 32'(bpDropCount), 32'(mStats));
`endif
    endtask

    initial begin
        logic [7:0]  nextSample;
        logic [31:0] expWord;
        bit          rv, rc, rs, rw;
        checks = 0;
        failures = 0;
        bpCyc = 0; bpStb = 0; bpWe = 0; bpValid = 0; bpData = 0;
        drCyc = 0; drStb = 0; drWe = 0; drValid = 0; drData = 0;
        resetModel();
        modelFire = 1'b0;

        $display("[TB] reset");
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #10;
        checkOutput("rst_ack", 32'(bpAck), 32'd0);
        checkOutput("rst_data", bpWbData, 32'd0);
        checkOutput("rst_count", 32'(bpCount), 32'd0);
        checkOutput("rst_empty", 32'(bpEmpty), 32'd1);
        checkOutput("rst_ready", 32'(bpReady), 32'd1);
        checkOutput("rst_full", 32'(bpFull), 32'd0);
        checkOutput("rst_underflow", 32'(bpUnder), 32'd0);
        checkOutput("rst_drop_empty", 32'(drEmpty), 32'd1);
        checkOutput("rst_drop_overflow", 32'(drOver), 32'd0);
        #11 rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] drop mode: 40 samples, no reads");
        for (int i = 0; i < 40; i++) begin
            drValid = 1'b1;
            drData  = 8'(i);
            checkOutput("drop_ready", 32'(drReady), 32'd1);
            @(posedge clk);
            #1;
        end
        drValid = 1'b0;
        checkOutput("drop_count", 32'(drCount), 32'd8);
        checkOutput("drop_full", 32'(drFull), 32'd1);
        checkOutput("drop_overflow", 32'(drOver), 32'd1);
`ifdef WB_RXFIFO_PACK_STATS_EN
        checkOutput("drop_drop_count", 32'(drDropCount), 32'd2);
`endif
        drCyc = 1'b1; drStb = 1'b1; drWe = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            expWord = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
            checkOutput("drop_ack", 32'(drAck), 32'd1);
            checkOutput("drop_word", drWbData, expWord);
        end
        drCyc = 1'b0; drStb = 1'b0;
        checkOutput("drop_drained", 32'(drCount), 32'd0);
        checkOutput("drop_overflow_sticky", 32'(drOver), 32'd1);
        drCyc = 1'b1; drStb = 1'b1; drWe = 1'b1;
        @(posedge clk);
        #1;
        drCyc = 1'b0; drStb = 1'b0; drWe = 1'b0;
        checkOutput("drop_flush_ack", 32'(drAck), 32'd1);
        checkOutput("drop_flush_data", drWbData, 32'd0);
        checkOutput("drop_flush_overflow", 32'(drOver), 32'd0);
`ifdef WB_RXFIFO_PACK_STATS_EN
        checkOutput("drop_flush_drop_count", 32'(drDropCount), 32'd0);
`endif

        $display("[TB] backpressure: fill with 32 samples");
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        checkOutput("bp_count_32", 32'(bpCount), 32'd8);
        checkOutput("bp_full_32", 32'(bpFull), 32'd1);

        $display("[TB] backpressure: keep streaming while full");
        nextSample = 8'h20;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, nextSample, 1'b0, 1'b0, 1'b0);
            if (modelFire) nextSample++;
        end
        checkOutput("bp_stalled_at", 32'(nextSample), 32'h23);
        applyStimulus(1'b1, nextSample, 1'b1, 1'b1, 1'b0);
        checkOutput("bp_first_word", bpWbData, 32'h03020100);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("bp_empty_after_drain", 32'(bpEmpty), 32'd1);

        $display("[TB] underflow then flush");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("bp_underflow_set", 32'(bpUnder), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_underflow_sticky", 32'(bpUnder), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        checkOutput("bp_flush_underflow", 32'(bpUnder), 32'd0);
        checkOutput("bp_flush_data", bpWbData, 32'd0);

        $display("[TB] random traffic, read-heavy then write-light");
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = $urandom_range(0, 1) == 1;
            rs = (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            rw = ($urandom_range(0, 24) == 0);
            applyStimulus(rv, 8'($urandom), rc, rs, rw);
        end

        $display("[TB] back-to-back reads while streaming");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        nextSample = 8'h60;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, nextSample, 1'b0, 1'b0, 1'b0);
            if (modelFire) nextSample++;
        end
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, nextSample, 1'b1, 1'b1, 1'b0);
            if (modelFire) nextSample++;
        end

        $display("[TB] async reset during a read");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_reset_ack", 32'(bpAck), 32'd1);
        checkOutput("pre_reset_word", bpWbData, 32'h43424140);
        checkOutput("pre_reset_count", 32'(bpCount), 32'd5);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_rst_ack", 32'(bpAck), 32'd0);
        checkOutput("async_rst_count", 32'(bpCount), 32'd0);
        checkOutput("async_rst_empty", 32'(bpEmpty), 32'd1);
        checkOutput("async_rst_half", 32'(bpHalf), 32'd0);
        checkOutput("async_rst_data", bpWbData, 32'd0);
        bpCyc = 1'b0; bpStb = 1'b0;
        resetModel();
        @(posedge clk);
        #3 rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_empty", 32'(bpEmpty), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_word", bpWbData, 32'hA3A2A1A0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_rxfifo_pack.md
Name: wb_rxfifo_pack

Overview:
- Parametrised successor to the single-channel Wishbone RX FIFO.
- Accepts a narrow valid/ready sample stream of RX_WIDTH bits and packs samples LSB-first into 32-bit words.
- Buffers the packed words in a 2^FIFO_ADDR_WIDTH-deep FIFO, which a Wishbone pipelined slave drains.
- Adds a selectable full policy (backpressure or drop), a flush command, sticky error flags and a programmable level flag.

Parameters:
- RX_WIDTH, 8: stream sample width; legal values 8, 16, 32.
- FIFO_ADDR_WIDTH, 3: FIFO depth is 2^FIFO_ADDR_WIDTH words.
- DROP_ON_FULL, 0: 0 = backpressure the stream when full; 1 = drop samples when full.
- LEVEL_THRESH, 4: o_fifo_level asserts when count >= LEVEL_THRESH.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  Wishbone write enable; a write means flush.
- o_wb_stall  out  1  Wishbone stall.
- o_wb_ack  out  1  Wishbone acknowledge.
- o_wb_data  out  32  Wishbone read data.
- i_rx_valid  in  1  stream valid.
- o_rx_ready  out  1  stream ready.
- i_rx_data  in  RX_WIDTH  stream sample.
- o_fifo_count  out  FIFO_ADDR_WIDTH+1  stored words, range 0..DEPTH.
- o_fifo_empty  out  1  count == 0.
- o_fifo_full  out  1  count == DEPTH.
- o_fifo_half_full  out  1  count >= DEPTH/2.
- o_fifo_level  out  1  count >= LEVEL_THRESH.
- o_fifo_overflow  out  1  sticky overflow flag.
- o_fifo_underflow  out  1  sticky underflow flag.

Behaviour:
- Reset (async, i_rst_n low): all outputs 0 except o_fifo_empty=1 and o_rx_ready=1. Count, packer slot index and sticky flags are cleared.
- Packing: SLOTS = 32/RX_WIDTH. A stream transfer happens when valid && ready.
  - Sample k of a word goes to bits [k*RX_WIDTH +: RX_WIDTH].
  - The transfer into slot SLOTS-1 pushes the completed word. It becomes visible in count on the next cycle.
  - RX_WIDTH=32 means every transfer pushes.
- Push rule: a push is allowed only when registered count < DEPTH. A simultaneous pop does not free space in the same cycle.
- Backpressure (DROP_ON_FULL=0): o_rx_ready = !(full && slot==SLOTS-1). Partial-word slots are still accepted while full. The overflow flag never sets in this mode.
- Drop mode (DROP_ON_FULL=1): o_rx_ready is constantly 1. A completing transfer while full discards the whole packed word, resets slot to 0 and sets o_fifo_overflow.
- Wishbone:
  - o_wb_stall is constantly 0. Each cyc&&stb cycle is one request.
  - o_wb_ack is asserted exactly 1 cycle after every accepted request, with registered data.
  - Read, count>0: pop, o_wb_data = head word.
  - Read, count==0: o_wb_data = 0, o_fifo_underflow set, no pop.
  - Write (flush): on the next cycle count=0, slot=0, both sticky flags cleared, o_wb_data=0. A stream transfer in the same cycle is discarded.
- When cyc drops, a pending ack still issues; the host ignores it.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Status flags are registered and derive from count. They change one cycle after the causing event.

Optional Feature:
- Macro: WB_RXFIFO_PACK_STATS_EN.
- Defined: adds output o_drop_count, 16 bits. It is a saturating count of words dropped (drop mode) or of cycles with valid && !ready (backpressure mode). Reset and flush clear it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package wb_rxfifo_pkg holds:
  - WB_DATA_WIDTH=32;
  - function slots(rx_width);
  - localparam for the drop-counter width (16).
- Natural sub-module: fifo_sync_mem, a dual-pointer RAM with registered read, parametrised by width and address width. Packer, policy, Wishbone logic and flags stay in the top.

Test Plan:
- RX_WIDTH=8, FIFO_ADDR_WIDTH=3, stream 0x00,0x01,... with no reads -> first read acks 0x03020100 one cycle after request; count 8 after 32 samples; o_fifo_full=1.
- Same setup, keep streaming -> samples 0x20..0x22 accepted, ready drops at 0x23; one read -> ready returns, next word after the remaining seven is 0x23222120; overflow stays 0.
- Empty FIFO, single read -> ack with 0x00000000, o_fifo_underflow=1 sticky; a subsequent write (flush) -> flag 0, count 0, ack data 0.
- DROP_ON_FULL=1, 40 samples, no reads -> count 8, overflow=1, ready never low; with STATS_EN, o_drop_count=2; reads return 0x03020100..0x1F1E1D1C.
- Back-to-back reads every cycle while streaming at 1 sample/cycle -> acks every cycle with data contiguous, and the level and half-full flags track count with 1-cycle latency.
- Assert i_rst_n low mid-read with count 5 -> ack, count and flags 0 immediately, without waiting for a clock edge; after release, empty=1 and the first word is built from new samples.
